// File: rtl/draw_arbiter_pkg.sv
// Shared constants and state encoding for the VGA write-port arbiter.
// DRAW_BORDER_EN (see draw_arbiter.sv) selects the outlined-block drawing mode.
package draw_arbiter_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam logic [X_W-1:0] SCREEN_W = 8'd160;
  localparam logic [Y_W-1:0] SCREEN_H = 7'd120;
  localparam logic [X_W-1:0] BLOCK_W  = 8'd20;
  localparam logic [Y_W-1:0] BLOCK_H  = 7'd8;

  localparam logic [C_W-1:0] BG_COLOUR     = 3'b000;
  localparam logic [C_W-1:0] BORDER_COLOUR = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERASE  = 3'd1,
    ST_DRAW   = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  function automatic logic is_work_state(input state_e s);
    return (s == ST_ERASE) || (s == ST_DRAW) || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/draw_arbiter_rect.sv
// rect_scanner: raster counter over a loadable w x h rectangle, x inner, y outer.
// i/j_nxt give the coordinate that will be current after the next clock edge.
module rect_scanner
  import draw_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           advance,
  input  logic [X_W-1:0] w_in,
  input  logic [Y_W-1:0] h_in,
  output logic [X_W-1:0] i_nxt,
  output logic [Y_W-1:0] j_nxt,
  output logic           last
);

  logic [X_W-1:0] i_q, w_q, w_d;
  logic [Y_W-1:0] j_q, h_q, h_d;

  always_comb begin
    i_nxt = i_q;
    j_nxt = j_q;
    w_d   = w_q;
    h_d   = h_q;
    if (start) begin
      i_nxt = '0;
      j_nxt = '0;
      w_d   = w_in;
      h_d   = h_in;
    end else if (advance) begin
      if (i_q == w_q - 8'd1) begin
        i_nxt = '0;
        j_nxt = (j_q == h_q - 7'd1) ? '0 : j_q + 7'd1;
      end else begin
        i_nxt = i_q + 8'd1;
      end
    end
  end

  assign last = (i_q == w_q - 8'd1) && (j_q == h_q - 7'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      w_q <= '0;
      h_q <= '0;
    end else begin
      i_q <= i_nxt;
      j_q <= j_nxt;
      w_q <= w_d;
      h_q <= h_d;
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates gameplay draw/move and screen-clear requests onto the VGA write port.
// Define DRAW_BORDER_EN to outline drawn blocks in BORDER_COLOUR.
//
// Handshake: a requester holds req high until its one-cycle ack; the ack
// appears together with the first work-state cycle, and requests seen while
// busy are simply left pending until the arbiter is back in IDLE.
module draw_arbiter
  import draw_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           game_req,
  input  logic           game_move,
  input  logic [X_W-1:0] game_x,
  input  logic [Y_W-1:0] game_y,
  input  logic [X_W-1:0] game_old_x,
  input  logic [C_W-1:0] game_colour,
  output logic           game_ack,
  input  logic           clr_req,
  output logic           clr_ack,
  output logic           busy,
  output logic           done,
  output logic           plot,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour
);

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d, old_x_q, old_x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] colour_q, colour_d;
  logic           game_ack_q, game_ack_d, clr_ack_q, clr_ack_d;
  logic           busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [X_W-1:0] vga_x_q, vga_x_d;
  logic [Y_W-1:0] vga_y_q, vga_y_d;
  logic [C_W-1:0] vga_colour_q, vga_colour_d;

  logic           scan_start, scan_advance, scan_last;
  logic [X_W-1:0] scan_w, scan_i;
  logic [Y_W-1:0] scan_h, scan_j;
  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic [X_W:0]   px;
  logic [Y_W:0]   py;

  rect_scanner u_scan (
    .clk     (clk),
    .rst_n   (resetn),
    .start   (scan_start),
    .advance (scan_advance),
    .w_in    (scan_w),
    .h_in    (scan_h),
    .i_nxt   (scan_i),
    .j_nxt   (scan_j),
    .last    (scan_last)
  );

  // Arbitration and sequencing; clear wins over a simultaneous game request.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    old_x_d      = old_x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    game_ack_d   = 1'b0;
    clr_ack_d    = 1'b0;
    scan_start   = 1'b0;
    scan_advance = 1'b0;
    scan_w       = BLOCK_W;
    scan_h       = BLOCK_H;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_ack_d  = 1'b1;
          scan_start = 1'b1;
          scan_w     = SCREEN_W;
          scan_h     = SCREEN_H;
        end else if (game_req) begin
          state_d    = game_move ? ST_ERASE : ST_DRAW;
          game_ack_d = 1'b1;
          scan_start = 1'b1;
          x_d        = game_x;
          old_x_d    = game_old_x;
          y_d        = game_y;
          colour_d   = game_colour;
        end
      end
      ST_ERASE: begin
        if (scan_last) begin
          state_d    = ST_DRAW;
          scan_start = 1'b1;
        end else begin
          scan_advance = 1'b1;
        end
      end
      ST_DRAW, ST_CLEAR: begin
        if (scan_last) state_d = ST_FINISH;
        else           scan_advance = 1'b1;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pixel stage: computed from next-cycle state so every output is a flop.
  always_comb begin
    base_x = '0;
    base_y = '0;
    case (state_d)
      ST_ERASE: begin base_x = old_x_d; base_y = y_d; end
      ST_DRAW:  begin base_x = x_d;     base_y = y_d; end
      default:  begin base_x = '0;      base_y = '0;  end
    endcase
    px = {1'b0, base_x} + {1'b0, scan_i};
    py = {1'b0, base_y} + {1'b0, scan_j};

    plot_d = is_work_state(state_d) && (px < {1'b0, SCREEN_W}) && (py < {1'b0, SCREEN_H});
    vga_x_d = px[X_W-1:0];
    vga_y_d = py[Y_W-1:0];

    vga_colour_d = BG_COLOUR;
    if (state_d == ST_DRAW) begin
`ifdef DRAW_BORDER_EN
      if ((scan_i == 8'd0) || (scan_i == BLOCK_W - 8'd1) ||
          (scan_j == 7'd0) || (scan_j == BLOCK_H - 7'd1))
        vga_colour_d = BORDER_COLOUR;
      else
        vga_colour_d = colour_d;
`else
      vga_colour_d = colour_d;
`endif
    end

    done_d = (state_d == ST_FINISH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      old_x_q      <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      game_ack_q   <= 1'b0;
      clr_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      old_x_q      <= old_x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      game_ack_q   <= game_ack_d;
      clr_ack_q    <= clr_ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
    end
  end

  assign game_ack   = game_ack_q;
  assign clr_ack    = clr_ack_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: table vectors, corner sequences and
// randomized requests scored against a pixel-list reference model.
module tb_draw_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       game_req, game_move, game_ack;
  logic [7:0] game_x, game_old_x;
  logic [6:0] game_y;
  logic [2:0] game_colour;
  logic       clr_req, clr_ack, busy, done, plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  typedef struct {
    bit move;
    int x;
    int old_x;
    int y;
    int colour;
    int exp_cycles;
    int exp_plots;
  } vec_t;

  vec_t vecs[6];

  draw_arbiter dut (
    .clk(clk), .resetn(resetn),
    .game_req(game_req), .game_move(game_move), .game_x(game_x), .game_y(game_y),
    .game_old_x(game_old_x), .game_colour(game_colour), .game_ack(game_ack),
    .clr_req(clr_req), .clr_ack(clr_ack), .busy(busy), .done(done),
    .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: list every visible pixel write in raster order.
  function automatic logic [17:0] pix(input int px, input int py, input int c);
    return 18'((px << 10) | (py << 3) | c);
  endfunction

  task automatic model_block(input int bx, input int by, input int c, input bit draw);
    int col;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 20; i++) begin
        if (!draw) col = 0;
`ifdef DRAW_BORDER_EN
        else if (i == 0 || i == 19 || j == 0 || j == 7) col = 7;
`endif
        else col = c;
        if (bx + i < 160 && by + j < 120) exp_q.push_back(pix(bx + i, by + j, col));
      end
    end
  endtask

  task automatic model_clear();
    for (int py = 0; py < 120; py++)
      for (int px = 0; px < 160; px++)
        exp_q.push_back(pix(px, py, 0));
  endtask

  // driver tasks
  task automatic wait_ack(input bit want_clr, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (want_clr ? clr_ack : game_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on the negedge of the ack cycle; returns on the negedge after done.
  task automatic sweep(input string name, input int exp_cycles,
                       output int plots, output int n_border);
    int cyc = 0;
    int bad = 0;
    logic [17:0] e;
    plots = 0;
    n_border = 0;
    while (!done && cyc < 25000) begin
      if (!busy) bad++;
      if (plot) begin
        plots++;
        if (vga_colour == 3'b111) n_border++;
        if (exp_q.size() == 0) bad++;
        else begin
          e = exp_q.pop_front();
          if ({vga_x, vga_y, vga_colour} !== e) bad++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    check({name, "_cycles"}, cyc, exp_cycles);
    check({name, "_pixel_errs"}, bad, 0);
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_done"}, int'(done), 1);
    check({name, "_busy_in_finish"}, int'(busy), 1);
    @(negedge clk);
    check({name, "_done_pulse"}, int'(done), 0);
    check({name, "_idle"}, int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic run_game(input string name, input vec_t v, input bit scramble,
                          output int plots, output int n_border);
    bit ok;
    exp_q.delete();
    if (v.move) model_block(v.old_x, v.y, 0, 1'b0);
    model_block(v.x, v.y, v.colour, 1'b1);
    game_move   = v.move;
    game_x      = 8'(v.x);
    game_old_x  = 8'(v.old_x);
    game_y      = 7'(v.y);
    game_colour = 3'(v.colour);
    game_req    = 1'b1;
    wait_ack(1'b0, ok);
    check({name, "_ack"}, int'(ok), 1);
    game_req = 1'b0;
    if (scramble) begin
      game_move   = 1'($urandom_range(0, 1));
      game_x      = 8'($urandom_range(0, 255));
      game_old_x  = 8'($urandom_range(0, 255));
      game_y      = 7'($urandom_range(0, 127));
      game_colour = 3'($urandom_range(0, 7));
    end
    sweep(name, v.exp_cycles, plots, n_border);
    if (v.exp_plots >= 0) check({name, "_plots"}, plots, v.exp_plots);
  endtask

  initial begin
    int plots, nb;
    bit ok;
    vec_t v;

    vecs[0] = '{move: 0, x: 40,  old_x: 0,  y: 100, colour: 4, exp_cycles: 160, exp_plots: 160};
    vecs[1] = '{move: 1, x: 45,  old_x: 40, y: 92,  colour: 3, exp_cycles: 320, exp_plots: 320};
    vecs[2] = '{move: 0, x: 150, old_x: 0,  y: 10,  colour: 5, exp_cycles: 160, exp_plots: 80};
    vecs[3] = '{move: 0, x: 0,   old_x: 0,  y: 116, colour: 6, exp_cycles: 160, exp_plots: 80};
    vecs[4] = '{move: 1, x: 250, old_x: 0,  y: 0,   colour: 1, exp_cycles: 320, exp_plots: 160};
    vecs[5] = '{move: 0, x: 0,   old_x: 0,  y: 0,   colour: 2, exp_cycles: 160, exp_plots: 160};

    // reset block
    resetn = 1'b0;
    game_req = 1'b0; game_move = 1'b0; game_x = '0; game_old_x = '0;
    game_y = '0; game_colour = '0; clr_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_acks", int'({game_ack, clr_ack}), 0);
    check("rst_vga", int'({vga_x, vga_y, vga_colour}), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // table-driven vectors
    for (int k = 0; k < 6; k++) begin
      run_game($sformatf("vec%0d", k), vecs[k], 1'b1, plots, nb);
      if (k == 5) begin
`ifdef DRAW_BORDER_EN
        check("border_edge_pixels", nb, 52);
        check("border_interior_pixels", plots - nb, 108);
`else
        check("noborder_edge_pixels", nb, 0);
`endif
      end
    end

    // clear and game requested together: clear first, game after FINISH
    exp_q.delete();
    model_clear();
    game_move = 1'b0; game_x = 8'd60; game_old_x = 8'd0; game_y = 7'd20; game_colour = 3'b110;
    clr_req = 1'b1;
    game_req = 1'b1;
    wait_ack(1'b1, ok);
    check("clr_ack", int'(ok), 1);
    check("clr_no_game_ack", int'(game_ack), 0);
    clr_req = 1'b0;
    sweep("clear", 19200, plots, nb);
    check("clear_plots", plots, 19200);
    model_block(60, 20, 6, 1'b1);
    wait_ack(1'b0, ok);
    check("pending_game_ack", int'(ok), 1);
    game_req = 1'b0;
    sweep("pending_game", 160, plots, nb);

    // asynchronous reset in the middle of a draw
    v = vecs[0];
    run_game_start: begin
      exp_q.delete();
      game_move = 1'b0; game_x = 8'd40; game_y = 7'd100; game_colour = 3'b100;
      game_req = 1'b1;
      wait_ack(1'b0, ok);
      check("mid_rst_ack", int'(ok), 1);
      game_req = 1'b0;
      repeat (50) @(negedge clk);
      check("mid_rst_plot_before", int'(plot), 1);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_plot_async", int'(plot), 0);
      check("mid_rst_busy_async", int'(busy), 0);
      nb = 0;
      repeat (4) begin
        @(negedge clk);
        if (done) nb++;
      end
      check("mid_rst_no_done", nb, 0);
      resetn = 1'b1;
      @(negedge clk);
    end
    run_game("after_rst", v, 1'b0, plots, nb);

    // randomized requests against the model
    for (int k = 0; k < 10; k++) begin
      v.move       = 1'($urandom_range(0, 1));
      v.x          = $urandom_range(0, 255);
      v.old_x      = $urandom_range(0, 255);
      v.y          = $urandom_range(0, 127);
      v.colour     = $urandom_range(0, 7);
      v.exp_cycles = v.move ? 320 : 160;
      v.exp_plots  = -1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_game($sformatf("rand%0d", k), v, 1'b1, plots, nb);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
